// File: rtl/fim_ram_fifo_ctrl_pkg.sv
// fim_ram_fifo_ctrl_pkg
// Shared definitions for the RAM-backed FIFO controller and its output buffer.
//   buf_depth()   : output buffer entries needed for a given RAM read latency
//   obuf_entry_t  : buffer entry layout {perr, data} at the default data width
package fim_ram_fifo_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // The output buffer holds one entry per possible in-flight read plus two,
  // so a steady stream never runs out of read credit.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  typedef struct packed {
    logic                     perr;
    logic [DEFAULT_WIDTH-1:0] data;
  } obuf_entry_t;

endpackage

// File: rtl/fim_ram_fifo_obuf.sv
// fim_ram_fifo_obuf
// Small register FIFO that captures RAM read returns until the consumer pops.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : remove the head entry (ignored when empty)
//   head        : current head entry (stale contents when empty)
//   occ         : number of stored entries
module fim_ram_fifo_obuf
  import fim_ram_fifo_ctrl_pkg::*;
#(
  parameter int  ENTRIES = 4,
  parameter type entry_t = obuf_entry_t,
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] occ
);

  entry_t           mem [ENTRIES];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_pop;

  // Entry count need not be a power of two, so indices wrap explicitly.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ENTRIES - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign do_pop = pop && (occ != '0);
  assign head   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_idx <= next_idx(wr_idx);
      if (do_pop) rd_idx <= next_idx(rd_idx);
      occ <= occ + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; only the indices define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_idx] <= push_entry;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (occ == CNT_W'(ENTRIES))));

endmodule

// File: rtl/fim_ram_fifo_ctrl.sv
// fim_ram_fifo_ctrl
// Streaming FIFO controller in front of a 1R1W simple dual-port RAM. Owns the
// RAM pointers and occupancy, spaces reads for the RAM write-to-read and read
// latencies, and buffers returned words (with parity flag) for the consumer.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid/in_ready/in_data        : producer stream
//   out_valid/out_ready/out_data     : consumer stream
//   out_perr                         : parity error flag of the head word
//   perr_sticky                      : any captured parity error since reset
//   occupancy                        : words accepted and not yet popped
//   ram_we/ram_waddr/ram_din         : RAM write port
//   ram_re/ram_raddr                 : RAM read port
//   ram_dout/ram_perr                : RAM read return, RD_LATENCY after ram_re
module fim_ram_fifo_ctrl
  import fim_ram_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH         = 5,
  parameter int WIDTH         = 32,
  parameter int RD_LATENCY    = 2,
  parameter int WR2RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_perr,
  output logic               perr_sticky,
  output logic [DEPTH+1:0]   occupancy,
  output logic               ram_we,
  output logic [DEPTH-1:0]   ram_waddr,
  output logic [WIDTH-1:0]   ram_din,
  output logic               ram_re,
  output logic [DEPTH-1:0]   ram_raddr,
  input  logic [WIDTH-1:0]   ram_dout,
  input  logic               ram_perr
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int RAM_WORDS = 2 ** DEPTH;

  // Same layout as obuf_entry_t, sized to this instance's data width.
  typedef struct packed {
    logic             perr;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [DEPTH-1:0]         wptr;
  logic [DEPTH-1:0]         rptr;
  logic [DEPTH:0]           ram_occ;
  logic [DEPTH:0]           rd_avail_q;
  logic [DEPTH:0]           rd_avail;
  logic [WR2RD_LATENCY-1:0] wr_pipe;
  logic                     push;
  logic                     pop;
  logic                     mature;
  logic                     credit_ok;
  logic                     issue;
  logic                     ret;
  logic [CNT_W-1:0]         buf_occ;
  logic [CNT_W-1:0]         inflight;
  entry_t                   ret_entry;
  entry_t                   head;

  // A RAM slot stays owned until its read data comes back, so a write can
  // never land on an address whose read is still in flight.
  assign in_ready  = !rst && (ram_occ < (DEPTH+1)'(RAM_WORDS));
  assign push      = in_valid && in_ready;
  assign ram_we    = push;
  assign ram_waddr = wptr;
  assign ram_din   = in_data;

  // The word leaving the write-delay line is readable in this same cycle.
  assign mature   = wr_pipe[WR2RD_LATENCY-1];
  assign rd_avail = rd_avail_q + (DEPTH+1)'(mature);

  // Credit counts buffer slots not yet spoken for by stored or in-flight words.
  assign credit_ok = (int'(buf_occ) + int'(inflight)) < BUF_DEPTH;
  assign issue     = !rst && (rd_avail != '0) && credit_ok;
  assign ram_re    = issue;
  assign ram_raddr = rptr;

  generate
    if (RD_LATENCY == 0) begin : g_rd_comb
      assign ret      = issue;
      assign inflight = '0;
    end else begin : g_rd_pipe
      logic [RD_LATENCY-1:0] rd_pipe;

      // Read-valid shift register: the top bit marks this cycle's return.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_pipe <= '0;
        end else begin
          rd_pipe[0] <= issue;
          for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
      end

      assign ret = rd_pipe[RD_LATENCY-1];

      always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(rd_pipe[i]);
      end
    end
  endgenerate

  assign ret_entry = '{perr: ram_perr, data: ram_dout};

  fim_ram_fifo_obuf #(
    .ENTRIES (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .push       (ret),
    .push_entry (ret_entry),
    .pop        (pop),
    .head       (head),
    .occ        (buf_occ)
  );

  assign out_valid = (buf_occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_perr  = out_valid && head.perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_occ     <= '0;
      rd_avail_q  <= '0;
      wr_pipe     <= '0;
      occupancy   <= '0;
      perr_sticky <= 1'b0;
    end else begin
      if (push) wptr <= wptr + DEPTH'(1);
      if (issue) rptr <= rptr + DEPTH'(1);
      ram_occ    <= ram_occ + (DEPTH+1)'(push) - (DEPTH+1)'(ret);
      rd_avail_q <= rd_avail - (DEPTH+1)'(issue);
      wr_pipe[0] <= push;
      for (int i = 1; i < WR2RD_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];
      occupancy  <= occupancy + (DEPTH+2)'(push) - (DEPTH+2)'(pop);
      if (ret && ram_perr) perr_sticky <= 1'b1;
    end
  end

  push_a: assert property (@(posedge clk) disable iff (rst)
    ram_we |-> (ram_occ < (DEPTH+1)'(RAM_WORDS)));

  issue_a: assert property (@(posedge clk) disable iff (rst)
    ram_re |-> (rd_avail != '0));

endmodule

// File: tb/tb_fim_ram_fifo_ctrl.sv
// tb_fim_ram_fifo_ctrl
// Bench for fim_ram_fifo_ctrl with default parameters. A RAM model with
// two-cycle read latency sits on the RAM ports; a queue of accepted words is
// the reference FIFO and is compared against the DUT every cycle.
module tb_fim_ram_fifo_ctrl;

  localparam int DEPTH         = 5;
  localparam int WIDTH         = 32;
  localparam int RD_LATENCY    = 2;
  localparam int WR2RD_LATENCY = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_perr;
  logic             perr_sticky;
  logic [DEPTH+1:0] occupancy;
  logic             ram_we;
  logic [DEPTH-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_din;
  logic             ram_re;
  logic [DEPTH-1:0] ram_raddr;
  logic [WIDTH-1:0] ram_dout;
  logic             ram_perr;

  int checks = 0;
  int fails  = 0;

  fim_ram_fifo_ctrl #(
    .DEPTH         (DEPTH),
    .WIDTH         (WIDTH),
    .RD_LATENCY    (RD_LATENCY),
    .WR2RD_LATENCY (WR2RD_LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_perr    (out_perr),
    .perr_sticky (perr_sticky),
    .occupancy   (occupancy),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_din     (ram_din),
    .ram_re      (ram_re),
    .ram_raddr   (ram_raddr),
    .ram_dout    (ram_dout),
    .ram_perr    (ram_perr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // RAM model: RAM port values are captured mid-cycle and acted on at the
  // next rising edge; read data emerges two cycles after ram_re.
  logic [WIDTH-1:0] ram_mem [2**DEPTH];
  logic             we_s, re_s;
  logic [DEPTH-1:0] waddr_s, raddr_s;
  logic [WIDTH-1:0] din_s;
  logic [WIDTH-1:0] rd_d1 = '0, rd_d2 = '0;
  bit               rd_v1, rd_v2;
  int               ret_count;
  bit               force_perr;
  bit               sticky_model;

  always @(negedge clk) begin
    we_s    = ram_we;
    waddr_s = ram_waddr;
    din_s   = ram_din;
    re_s    = ram_re;
    raddr_s = ram_raddr;
  end

  always @(posedge clk) begin
    if (we_s) ram_mem[waddr_s] <= din_s;
    rd_d1 <= ram_mem[raddr_s];
    rd_d2 <= rd_d1;
    rd_v1 <= re_s;
    rd_v2 <= rd_v1;
    if (rst) begin
      ret_count    <= 0;
      sticky_model <= 1'b0;
    end else if (rd_v2) begin
      ret_count <= ret_count + 1;
      if (force_perr && ret_count == 2) sticky_model <= 1'b1;
    end
  end

  assign ram_dout = rd_d2;
  assign ram_perr = rd_v2 && force_perr && (ret_count == 2);

  // Reference FIFO: each accepted word with its sequence number since reset.
  // Returns come back in push order, so the third return is sequence 2.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               seq;
  } item_t;

  item_t            model_q[$];
  int               push_seq;
  bit               model_live;
  int               cyc;
  bit               stalled_prev;
  logic [WIDTH-1:0] stalled_data;
  logic             stalled_perr;
  int               perr_pops;
  bit               track_stream;
  int               stream_pops;
  int               stream_first = -1;
  int               stream_last  = -1;

  always @(negedge clk) begin
    item_t exp_item;
    cyc++;
    if (model_live) begin
      checkOutput("occupancy", occupancy, model_q.size());
      checkOutput("perr_sticky", perr_sticky, sticky_model);
      if (out_valid && model_q.size() == 0) checkOutput("valid_when_empty", out_valid, 0);
      if (stalled_prev) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, stalled_data);
        checkOutput("hold_perr", out_perr, stalled_perr);
      end
      if (!rst && out_valid && out_ready && model_q.size() != 0) begin
        exp_item = model_q.pop_front();
        checkOutput("pop_data", out_data, exp_item.data);
        checkOutput("pop_perr", out_perr, force_perr && (exp_item.seq == 2));
        if (out_perr) perr_pops++;
        if (track_stream) begin
          stream_pops++;
          if (stream_first < 0) stream_first = cyc;
          stream_last = cyc;
        end
      end
    end
    if (rst) begin
      model_q.delete();
      push_seq     = 0;
      model_live   = 1'b1;
      stalled_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        model_q.push_back('{data: in_data, seq: push_seq});
        push_seq++;
      end
      stalled_prev = out_valid && !out_ready;
      stalled_data = out_data;
      stalled_perr = out_perr;
    end
  end

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_during_rst", in_ready, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (model_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, model_q.size(), 0);
    @(negedge clk);
    checkOutput({name, "_occ"}, occupancy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    int stalls;
    int n;

    // Reset and reset values
    resetDut();
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_perr", out_perr, 0);
    checkOutput("rst_sticky", perr_sticky, 0);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_re", ram_re, 0);
    checkOutput("rst_waddr", ram_waddr, 0);
    checkOutput("rst_raddr", ram_raddr, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single word: out_valid five cycles after the push
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("single_we", ram_we, 1);
    checkOutput("single_waddr", ram_waddr, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("single_valid_t%0d", k), out_valid, (k == 5));
      if (k < 5) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("single_data", out_data, 32'hA5A5_0001);
    checkOutput("single_occ_before_pop", occupancy, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("single_occ_after_pop", occupancy, 0);
    checkOutput("single_valid_after_pop", out_valid, 0);
    @(posedge clk);
    #1;

    // Fill to full with the consumer stalled
    resetDut();
    accepted  = 0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    checkOutput("fill_accepted", accepted, 36);
    @(negedge clk);
    checkOutput("fill_in_ready", in_ready, 0);
    checkOutput("fill_occupancy", occupancy, 36);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    checkOutput("refill_accepted", accepted, 1);
    drain("fill_drain");

    // Streaming 1000 words back-to-back with the consumer always ready
    resetDut();
    stalls       = 0;
    track_stream = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'b1;
      in_data   = i;
      out_ready = 1'b1;
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    drain("stream_drain");
    track_stream = 1'b0;
    checkOutput("stream_stalls", stalls, 0);
    checkOutput("stream_pops", stream_pops, 1000);
    checkOutput("stream_no_bubble", stream_last - stream_first + 1, 1000);

    // Random valid/ready at 50%
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    drain("random_drain");

    // Parity error injected on the third return
    force_perr = 1'b1;
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hBEEF_0000 + i, 1'b1);
    drain("perr_drain");
    checkOutput("perr_pop_count", perr_pops, 1);
    checkOutput("perr_sticky_set", perr_sticky, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b1);
    drain("perr_drain2");
    checkOutput("perr_sticky_held", perr_sticky, 1);
    resetDut();
    force_perr = 1'b0;
    @(negedge clk);
    checkOutput("perr_sticky_cleared", perr_sticky, 0);
    @(posedge clk);
    #1;

    // Reset with words queued and reads in flight
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hC0DE_0000 + i, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("midflight_occ", occupancy, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midflight_valid", out_valid, 0);
    checkOutput("midflight_occupancy", occupancy, 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h1234_5678, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    checkOutput("fresh_valid", out_valid, 1);
    checkOutput("fresh_data", out_data, 32'h1234_5678);
    @(posedge clk);
    #1;
    drain("fresh_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
